uart_cmd_rx: RTL and testbench

- Receive-side counterpart of the ALU result UART transmitter.
- Deserialises 8N1 UART bytes from the `rx` pin and assembles two-byte command frames: a header carrying the opcode, then an operand byte carrying a/b.
- Presents each complete command to the FSM core as a registered a/b/opcode set with a one-cycle `cmd_valid` strobe, so the core can be driven over serial instead of `ui_in`/`uio_in`.

---
 rtl/uart_cmd_rx.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver assembling {header(opcode), operand(a,b)} command frames with strobed outputs
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter logic [4:0] HDR_TAG = 5'b10100,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [2:0] opcode,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       hdr_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TO_N = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_N + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TO_N);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic {WAIT_HDR, WAIT_OPD} asm_state_t;
  logic rx_m, rx_s;
  rx_state_t rx_state, rx_next;
  asm_state_t asm_state, asm_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0] bit_idx, bit_next;
  logic [7:0] shreg, sh_next;
  logic [2:0] pend_op, pend_next;
  logic [TW-1:0] tmo, tmo_next;
  logic byte_done, ferr_now, cmd_now, hdr_now, tick_full;
  assign busy = (rx_state != RX_IDLE) || (asm_state != WAIT_HDR);
  assign tick_full = cnt == FULL_M1;
  always_comb begin
    rx_next = rx_state;
    cnt_next = cnt + 1'b1;
    bit_next = bit_idx;
    sh_next = shreg;
    byte_done = 1'b0;
    ferr_now = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_next = '0;
        rx_next = rx_s ? RX_IDLE : RX_START;
      end
      RX_START: if (cnt == HALF_M1) begin
        cnt_next = '0;
        bit_next = '0;
        rx_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick_full) begin
        cnt_next = '0;
        sh_next = {rx_s, shreg[7:1]};
        bit_next = bit_idx + 3'd1;
        rx_next = (bit_idx == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (tick_full) begin
        cnt_next = '0;
        byte_done = rx_s;
        ferr_now = !rx_s;
        rx_next = rx_s ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        cnt_next = '0;
        rx_next = rx_s ? RX_IDLE : RX_BREAK;
      end
      default: rx_next = RX_IDLE;
    endcase
  end
  always_comb begin
    asm_next = asm_state;
    pend_next = pend_op;
    tmo_next = tmo;
    cmd_now = 1'b0;
    hdr_now = 1'b0;
    if (asm_state == WAIT_HDR) begin
      if (byte_done && shreg[7:3] == HDR_TAG) begin
        asm_next = WAIT_OPD;
        pend_next = shreg[2:0];
        tmo_next = TO_LOAD;
      end
      hdr_now = byte_done && shreg[7:3] != HDR_TAG;
    end else begin
      tmo_next = tmo - 1'b1;
      cmd_now = byte_done;
      hdr_now = !byte_done && !ferr_now && tmo <= TW'(1);
      asm_next = (byte_done || ferr_now || hdr_now) ? WAIT_HDR : WAIT_OPD;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_state <= RX_IDLE;
      asm_state <= WAIT_HDR;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      pend_op <= '0;
      tmo <= '0;
      rx_byte <= '0;
      opcode <= '0;
      a <= '0;
      b <= '0;
      rx_byte_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_valid <= 1'b0;
      hdr_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_byte_valid <= ena && byte_done;
      frame_err <= ena && ferr_now;
      cmd_valid <= ena && cmd_now;
      hdr_err <= ena && hdr_now;
      if (!ena) begin
        rx_state <= RX_IDLE;
        asm_state <= WAIT_HDR;
        cnt <= '0;
      end else begin
        rx_state <= rx_next;
        asm_state <= asm_next;
        cnt <= cnt_next;
        bit_idx <= bit_next;
        shreg <= sh_next;
        pend_op <= pend_next;
        tmo <= tmo_next;
        if (byte_done) rx_byte <= shreg;
        if (cmd_now) begin
          opcode <= pend_op;
          a <= shreg[7:4];
          b <= shreg[3:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scoreboard bench driving serial command frames into uart_cmd_rx
module tb_uart_cmd_rx;
  localparam int CPB = 16;
  logic clock = 1'b0, reset = 1'b1, ena = 1'b1, rx = 1'b1;
  logic [7:0] rx_byte;
  logic rx_byte_valid, cmd_valid, frame_err, hdr_err, busy;
  logic [2:0] opcode;
  logic [3:0] a, b;
  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .HDR_TAG(5'b10100), .TIMEOUT_BITS(20)) dut (
    .clock(clock), .reset(reset), .ena(ena), .rx(rx), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .opcode(opcode), .a(a), .b(b),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .hdr_err(hdr_err), .busy(busy)
  );
  always #5 clock = ~clock;
  int vectors = 0, miscompares = 0;
  longint cyc = 0, last_valid = 0;
  logic [7:0] byte_q[$];
  logic [10:0] cmd_q[$];
  int hdr_q[$];
  int fe_q[$];
  logic [3:0] prev = '0;
  logic [7:0] eb;
  logic [10:0] ec;
  int ed;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_byte_valid) begin
        vectors++;
        if (byte_q.size() == 0) begin
          miscompares++;
          $display("FAIL rx_byte unexpected: got %02h required none", rx_byte);
        end else begin
          eb = byte_q.pop_front();
          if (rx_byte !== eb) begin
            miscompares++;
            $display("FAIL rx_byte: got %02h required %02h", rx_byte, eb);
          end
        end
      end
      if (cmd_valid) begin
        vectors++;
        if (cmd_q.size() == 0) begin
          miscompares++;
          $display("FAIL cmd unexpected: got op=%0d a=%0d b=%0d required none", opcode, a, b);
        end else begin
          ec = cmd_q.pop_front();
          if ({opcode, a, b} !== ec) begin
            miscompares++;
            $display("FAIL cmd: got op=%0d a=%0d b=%0d required op=%0d a=%0d b=%0d",
                     opcode, a, b, ec[10:8], ec[7:4], ec[3:0]);
          end
        end
      end
      if (frame_err) begin
        vectors++;
        if (fe_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_err unexpected: got 1 required 0");
        end else void'(fe_q.pop_front());
      end
      if (hdr_err) begin
        vectors++;
        if (hdr_q.size() == 0) begin
          miscompares++;
          $display("FAIL hdr_err unexpected: got 1 required 0");
        end else begin
          ed = hdr_q.pop_front();
          if (ed != 0 && cyc - last_valid != longint'(ed)) begin
            miscompares++;
            $display("FAIL hdr_err timing: got %0d cycles required %0d", cyc - last_valid, ed);
          end
        end
      end
      if (rx_byte_valid && frame_err) begin
        miscompares++;
        $display("FAIL strobe_excl rx_byte_valid/frame_err: got both required one");
      end
      if (cmd_valid && hdr_err) begin
        miscompares++;
        $display("FAIL strobe_excl cmd_valid/hdr_err: got both required one");
      end
      if ((prev & {rx_byte_valid, cmd_valid, frame_err, hdr_err}) != 4'b0) begin
        miscompares++;
        $display("FAIL strobe_width: got %b twice required single cycle", prev);
      end
      if (rx_byte_valid) last_valid = cyc;
    end
    prev = {rx_byte_valid, cmd_valid, frame_err, hdr_err};
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(CPB);
    end
  endtask
  task automatic send_partial(input logic [7:0] d, input int n);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      tick(CPB);
    end
  endtask
  task automatic send_cmd(input logic [7:0] h, input logic [7:0] o);
    byte_q.push_back(h);
    byte_q.push_back(o);
    cmd_q.push_back({h[2:0], o});
    send_byte(h, 1'b1);
    send_byte(o, 1'b1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int seen;
    tick(3);
    check("reset rx_byte", rx_byte, 0);
    check("reset opcode", opcode, 0);
    check("reset a", a, 0);
    check("reset b", b, 0);
    check("reset busy", busy, 0);
    check("reset strobes", {rx_byte_valid, cmd_valid, frame_err, hdr_err}, 0);
    reset = 1'b0;
    tick(CPB * 2);
    send_cmd(8'hA3, 8'h5C);
    tick(CPB * 4);
    check("held opcode", opcode, 3);
    check("held a", a, 5);
    check("held b", b, 12);
    byte_q.push_back(8'h7F);
    hdr_q.push_back(0);
    send_byte(8'h7F, 1'b1);
    tick(CPB);
    send_cmd(8'hA1, 8'h21);
    tick(CPB);
    fe_q.push_back(1);
    send_byte(8'h55, 1'b0);
    tick(CPB * 40);
    check("break busy", busy, 1);
    check("break rx_byte held", rx_byte, 8'h21);
    rx = 1'b1;
    tick(5);
    check("break released busy", busy, 0);
    tick(CPB);
    send_cmd(8'hA0, 8'h00);
    tick(CPB);
    byte_q.push_back(8'hA2);
    hdr_q.push_back(320);
    send_byte(8'hA2, 1'b1);
    tick(CPB * 25);
    check("after timeout busy", busy, 0);
    send_cmd(8'hA5, 8'h3C);
    tick(CPB);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("glitch busy", busy, 1);
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      tick(1);
      if (!busy) seen = 1;
    end
    check("glitch busy drops", seen, 1);
    tick(CPB * 2);
    byte_q.push_back(8'hA4);
    send_byte(8'hA4, 1'b1);
    send_partial(8'h99, 4);
    ena = 1'b0;
    rx = 1'b1;
    tick(3);
    check("ena low busy", busy, 0);
    tick(CPB * 12);
    ena = 1'b1;
    tick(CPB);
    send_cmd(8'hA4, 8'h99);
    tick(CPB * 2);
    byte_q.push_back(8'hA4);
    send_byte(8'hA4, 1'b1);
    send_partial(8'h99, 4);
    reset = 1'b1;
    tick(3);
    rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("mid reset rx_byte", rx_byte, 0);
    check("mid reset opcode", opcode, 0);
    check("mid reset a", a, 0);
    check("mid reset b", b, 0);
    check("mid reset busy", busy, 0);
    tick(CPB * 4);
    byte_q.push_back(8'hA4);
    send_byte(8'hA4, 1'b1);
    check("pre cmd opcode", opcode, 0);
    check("pre cmd a", a, 0);
    check("pre cmd b", b, 0);
    byte_q.push_back(8'h99);
    cmd_q.push_back({3'd4, 8'h99});
    send_byte(8'h99, 1'b1);
    tick(CPB * 4);
    check("leftover bytes", byte_q.size(), 0);
    check("leftover cmds", cmd_q.size(), 0);
    check("leftover hdr_err", hdr_q.size(), 0);
    check("leftover frame_err", fe_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
